// File: rtl/cplx_dot_sched.sv
// cplx_dot_sched: groups a complex operand stream into LEN-element dot products for an external MAC and queues the sums
module cplx_dot_sched #(
  parameter int AW = 18,
  parameter int BW = 18,
  parameter int PW = 58,
  parameter int LEN = 8,
  parameter int LAT = 4,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [AW-1:0] s_ar,
  input  logic [AW-1:0] s_ai,
  input  logic [BW-1:0] s_br,
  input  logic [BW-1:0] s_bi,
  output logic          mac_sload,
  output logic [AW-1:0] mac_ar,
  output logic [AW-1:0] mac_ai,
  output logic [BW-1:0] mac_br,
  output logic [BW-1:0] mac_bi,
  input  logic [PW-1:0] mac_pr,
  input  logic [PW-1:0] mac_pi,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [PW-1:0] m_pr,
  output logic [PW-1:0] m_pi,
  output logic          busy
);
  localparam int IW = LEN > 1 ? $clog2(LEN) : 1;
  localparam int FW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int NW = FW + 1;
  localparam int CW = $clog2(DEPTH + LAT + 2) + 1;
  logic [IW-1:0] idx;
  logic [LAT:0] tag;
  logic [FW-1:0] wp;
  logic [FW-1:0] rp;
  logic [NW-1:0] cnt;
  logic [PW-1:0] mem_r [DEPTH];
  logic [PW-1:0] mem_i [DEPTH];
  logic [CW-1:0] occ;
  logic is_last;
  logic acc;
  logic push;
  logic pop;
  assign is_last = idx == IW'(LEN - 1);
  // slots already claimed: stored results plus vector ends still travelling through the MAC
  always_comb begin
    occ = CW'(cnt);
    for (int i = 0; i <= LAT; i++) occ = occ + CW'(tag[i]);
  end
  assign s_ready = !rst && !(is_last && occ >= CW'(DEPTH));
  assign acc = s_valid && s_ready;
  assign push = tag[LAT];
  assign m_valid = cnt != '0;
  assign pop = m_valid && m_ready;
  assign m_pr = m_valid ? mem_r[rp] : '0;
  assign m_pi = m_valid ? mem_i[rp] : '0;
  assign busy = idx != '0 || tag != '0 || m_valid;
  // element position within the current vector, advanced per accepted element
  always_ff @(posedge clk) begin
    if (rst) idx <= '0;
    else if (acc) idx <= is_last ? '0 : idx + IW'(1);
  end
  // registered MAC drive; idle cycles feed zeros so the running sum holds
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_sload <= 1'b0;
      mac_ar <= '0;
      mac_ai <= '0;
      mac_br <= '0;
      mac_bi <= '0;
    end else begin
      mac_sload <= acc && idx == '0;
      mac_ar <= acc ? s_ar : '0;
      mac_ai <= acc ? s_ai : '0;
      mac_br <= acc ? s_br : '0;
      mac_bi <= acc ? s_bi : '0;
    end
  end
  // vector-end marker follows the last element through the MAC latency
  always_ff @(posedge clk) begin
    if (rst) tag <= '0;
    else tag <= {tag[LAT-1:0], acc && is_last};
  end
  // result FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= push ? wp + FW'(1) : wp;
      rp <= pop ? rp + FW'(1) : rp;
      cnt <= cnt + NW'(push) - NW'(pop);
    end
  end
  // capture the finished sum on the cycle its marker leaves the pipe
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wp] <= mac_pr;
      mem_i[wp] <= mac_pi;
    end
  end
endmodule

// File: tb/tb_cplx_dot_sched.sv
// tb_cplx_dot_sched: table, hand-written and random checks of the dot-product sequencer against a complex-arithmetic model
module tb_cplx_dot_sched;
  localparam int AW = 18;
  localparam int BW = 18;
  localparam int PW = 58;
  localparam int LEN = 4;
  localparam int LAT = 4;
  localparam int DEPTH = 4;
  typedef struct {
    longint ar, ai, br, bi, er, ei;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  logic rnd_mr = 0;
  always #5 clk = ~clk;
  logic s_valid = 0, m_ready = 0;
  logic [AW-1:0] s_ar = 0, s_ai = 0;
  logic [BW-1:0] s_br = 0, s_bi = 0;
  logic s_ready, mac_sload, m_valid, busy;
  logic [AW-1:0] mac_ar, mac_ai;
  logic [BW-1:0] mac_br, mac_bi;
  logic [PW-1:0] mac_pr, mac_pi, m_pr, m_pi;
  logic b_s_valid = 0, b_m_ready = 0;
  logic [AW-1:0] b_s_ar = 0, b_s_ai = 0;
  logic [BW-1:0] b_s_br = 0, b_s_bi = 0;
  logic b_s_ready, b_mac_sload, b_m_valid, b_busy;
  logic [AW-1:0] b_mac_ar, b_mac_ai;
  logic [BW-1:0] b_mac_br, b_mac_bi;
  logic [PW-1:0] b_mac_pr, b_mac_pi, b_m_pr, b_m_pi;
  cplx_dot_sched #(.AW(AW), .BW(BW), .PW(PW), .LEN(LEN), .LAT(LAT), .DEPTH(DEPTH)) u_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_ar(s_ar), .s_ai(s_ai), .s_br(s_br), .s_bi(s_bi),
    .mac_sload(mac_sload), .mac_ar(mac_ar), .mac_ai(mac_ai), .mac_br(mac_br), .mac_bi(mac_bi),
    .mac_pr(mac_pr), .mac_pi(mac_pi), .m_valid(m_valid), .m_ready(m_ready),
    .m_pr(m_pr), .m_pi(m_pi), .busy(busy));
  cplx_dot_sched #(.AW(AW), .BW(BW), .PW(PW), .LEN(1), .LAT(LAT), .DEPTH(DEPTH)) u_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .s_ar(b_s_ar), .s_ai(b_s_ai), .s_br(b_s_br), .s_bi(b_s_bi),
    .mac_sload(b_mac_sload), .mac_ar(b_mac_ar), .mac_ai(b_mac_ai), .mac_br(b_mac_br), .mac_bi(b_mac_bi),
    .mac_pr(b_mac_pr), .mac_pi(b_mac_pi), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .m_pr(b_m_pr), .m_pi(b_m_pi), .busy(b_busy));
  function automatic longint cre(input logic signed [AW-1:0] ar, ai, input logic signed [BW-1:0] br, bi);
    return longint'(ar) * longint'(br) - longint'(ai) * longint'(bi);
  endfunction
  function automatic longint cim(input logic signed [AW-1:0] ar, ai, input logic signed [BW-1:0] br, bi);
    return longint'(ar) * longint'(bi) + longint'(ai) * longint'(br);
  endfunction
  task automatic check(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  // accumulator models: operands at cycle c show up in the result at c+LAT
  logic sl_a [LAT-1];
  longint pr_a [LAT-1], pi_a [LAT-1];
  longint acc_ar = 0, acc_ai = 0;
  logic sl_b [LAT-1];
  longint pr_b [LAT-1], pi_b [LAT-1];
  longint acc_br = 0, acc_bi = 0;
  always @(posedge clk) begin
    sl_a[0] <= mac_sload;
    pr_a[0] <= cre(mac_ar, mac_ai, mac_br, mac_bi);
    pi_a[0] <= cim(mac_ar, mac_ai, mac_br, mac_bi);
    sl_b[0] <= b_mac_sload;
    pr_b[0] <= cre(b_mac_ar, b_mac_ai, b_mac_br, b_mac_bi);
    pi_b[0] <= cim(b_mac_ar, b_mac_ai, b_mac_br, b_mac_bi);
    for (int i = 1; i < LAT - 1; i++) begin
      sl_a[i] <= sl_a[i-1];
      pr_a[i] <= pr_a[i-1];
      pi_a[i] <= pi_a[i-1];
      sl_b[i] <= sl_b[i-1];
      pr_b[i] <= pr_b[i-1];
      pi_b[i] <= pi_b[i-1];
    end
    acc_ar <= sl_a[LAT-2] ? pr_a[LAT-2] : acc_ar + pr_a[LAT-2];
    acc_ai <= sl_a[LAT-2] ? pi_a[LAT-2] : acc_ai + pi_a[LAT-2];
    acc_br <= sl_b[LAT-2] ? pr_b[LAT-2] : acc_br + pr_b[LAT-2];
    acc_bi <= sl_b[LAT-2] ? pi_b[LAT-2] : acc_bi + pi_b[LAT-2];
  end
  assign mac_pr = acc_ar[PW-1:0];
  assign mac_pi = acc_ai[PW-1:0];
  assign b_mac_pr = acc_br[PW-1:0];
  assign b_mac_pi = acc_bi[PW-1:0];
  // scoreboard for the LEN=4 instance: dot products of accepted elements, in order
  longint qr[$], qi[$];
  longint sr = 0, si = 0;
  int ne = 0;
  int pops_a = 0;
  logic e_sl = 0;
  logic [AW-1:0] e_ar = 0, e_ai = 0;
  logic [BW-1:0] e_br = 0, e_bi = 0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      qr.delete(); qi.delete(); ne = 0;
      e_sl = 0; e_ar = 0; e_ai = 0; e_br = 0; e_bi = 0;
    end else begin
      check("a_mac_sload", mac_sload, e_sl);
      check("a_mac_ar", mac_ar, e_ar);
      check("a_mac_ai", mac_ai, e_ai);
      check("a_mac_br", mac_br, e_br);
      check("a_mac_bi", mac_bi, e_bi);
      if (m_valid && m_ready) begin
        check("a_res_expected", qr.size() > 0, 1);
        if (qr.size() > 0) begin
          check("a_res_pr", $signed(m_pr), qr.pop_front());
          check("a_res_pi", $signed(m_pi), qi.pop_front());
        end
        pops_a++;
      end
      e_sl = s_valid && s_ready && ne == 0;
      e_ar = (s_valid && s_ready) ? s_ar : '0;
      e_ai = (s_valid && s_ready) ? s_ai : '0;
      e_br = (s_valid && s_ready) ? s_br : '0;
      e_bi = (s_valid && s_ready) ? s_bi : '0;
      if (s_valid && s_ready) begin
        if (ne == 0) begin sr = 0; si = 0; end
        sr += cre(s_ar, s_ai, s_br, s_bi);
        si += cim(s_ar, s_ai, s_br, s_bi);
        ne++;
        if (ne == LEN) begin qr.push_back(sr); qi.push_back(si); ne = 0; end
      end
    end
  end
  // scoreboard for the LEN=1 instance: every element is its own vector
  longint qbr[$], qbi[$];
  int pops_b = 0;
  logic e_bsl = 0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      qbr.delete(); qbi.delete(); e_bsl = 0;
    end else begin
      check("b_mac_sload", b_mac_sload, e_bsl);
      if (b_m_valid && b_m_ready) begin
        check("b_res_expected", qbr.size() > 0, 1);
        if (qbr.size() > 0) begin
          check("b_res_pr", $signed(b_m_pr), qbr.pop_front());
          check("b_res_pi", $signed(b_m_pi), qbi.pop_front());
        end
        pops_b++;
      end
      e_bsl = b_s_valid && b_s_ready;
      if (b_s_valid && b_s_ready) begin
        qbr.push_back(cre(b_s_ar, b_s_ai, b_s_br, b_s_bi));
        qbi.push_back(cim(b_s_ar, b_s_ai, b_s_br, b_s_bi));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mr) m_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic send(input logic [AW-1:0] ar, ai, input logic [BW-1:0] br, bi);
    int n = 0;
    s_valid = 1; s_ar = ar; s_ai = ai; s_br = br; s_bi = bi;
    @(negedge clk);
    while (!s_ready && n < 200) begin tick(); @(negedge clk); n++; end
    check("send_accept", s_ready, 1);
    tick();
    s_valid = 0;
  endtask
  task automatic send_b(input logic [AW-1:0] ar, ai, input logic [BW-1:0] br, bi);
    int n = 0;
    b_s_valid = 1; b_s_ar = ar; b_s_ai = ai; b_s_br = br; b_s_bi = bi;
    @(negedge clk);
    while (!b_s_ready && n < 200) begin tick(); @(negedge clk); n++; end
    check("send_b_accept", b_s_ready, 1);
    tick();
  endtask
  task automatic send_rnd();
    send(AW'($urandom()), AW'($urandom()), BW'($urandom()), BW'($urandom()));
  endtask
  task automatic wait_result(input longint er, input longint ei, input string nm);
    int n = 0;
    @(negedge clk);
    while (!m_valid && n < 100) begin tick(); @(negedge clk); n++; end
    check({nm, "_valid"}, m_valid, 1);
    check({nm, "_pr"}, $signed(m_pr), er);
    check({nm, "_pi"}, $signed(m_pi), ei);
    tick();
  endtask
  task automatic drain(input string nm);
    int n = 0;
    while ((qr.size() != 0 || m_valid) && n < 300) begin tick(); n++; end
    check({nm, "_queue_empty"}, qr.size(), 0);
    @(negedge clk);
    check({nm, "_busy_idle"}, busy, 0);
    tick();
  endtask
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    vec_t tbl[6];
    logic [AW-1:0] har, hai;
    logic [BW-1:0] hbr, hbi;
    int p0;
    tbl[0] = '{1, 2, 3, 4, -20, 40};
    tbl[1] = '{1, 0, 1, 0, 4, 0};
    tbl[2] = '{0, 1, 0, 1, -4, 0};
    tbl[3] = '{2, -3, -1, 5, 52, 52};
    tbl[4] = '{10, 0, 10, 0, 400, 0};
    tbl[5] = '{-5, 7, 3, -2, -4, 124};
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mac_sload", mac_sload, 0);
    check("rst_mac_ar", mac_ar, 0);
    check("rst_m_pr", m_pr, 0);
    check("rst_b_s_ready", b_s_ready, 0);
    tick();
    rst = 0;
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1);
    check("post_rst_busy", busy, 0);
    tick();
    // single vector with exact latency and a one-cycle result pulse
    m_ready = 1;
    for (int i = 0; i < LEN; i++) begin
      send(1, 2, 3, 4);
      check("t1_sload", mac_sload, i == 0);
    end
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      check("t1_early_valid", m_valid, 0);
      tick();
    end
    @(negedge clk);
    check("t1_valid", m_valid, 1);
    check("t1_pr", $signed(m_pr), -20);
    check("t1_pi", $signed(m_pi), 40);
    tick();
    @(negedge clk);
    check("t1_pulse_once", m_valid, 0);
    tick();
    // three idle cycles between elements 2 and 3
    send(1, 2, 3, 4);
    send(1, 2, 3, 4);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_gap_sload", mac_sload, 0);
      check("t2_gap_ar", mac_ar, 0);
      check("t2_gap_bi", mac_bi, 0);
    end
    send(1, 2, 3, 4);
    send(1, 2, 3, 4);
    wait_result(-20, 40, "t2_stall");
    // table of constant vectors
    for (int r = 0; r < 6; r++) begin
      for (int e = 0; e < LEN; e++)
        send(AW'(tbl[r].ar), AW'(tbl[r].ai), BW'(tbl[r].br), BW'(tbl[r].bi));
      wait_result(tbl[r].er, tbl[r].ei, "tbl");
    end
    // back-to-back vectors with no bleed
    for (int e = 0; e < LEN; e++) send(1, 0, 1, 0);
    for (int e = 0; e < LEN; e++) send(0, 1, 0, 1);
    wait_result(4, 0, "t3_first");
    wait_result(-4, 0, "t3_second");
    // backpressure: the fifth vector's last element must wait for a free slot
    m_ready = 0;
    p0 = pops_a;
    for (int e = 0; e < 4 * LEN + LEN - 1; e++) send_rnd();
    har = AW'($urandom()); hai = AW'($urandom()); hbr = BW'($urandom()); hbi = BW'($urandom());
    s_valid = 1; s_ar = har; s_ai = hai; s_br = hbr; s_bi = hbi;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t4_blocked", s_ready, 0);
      check("t4_held_valid", m_valid, 1);
      check("t4_held_pr", $signed(m_pr), qr[0]);
      tick();
    end
    m_ready = 1;
    send(har, hai, hbr, hbi);
    for (int e = 0; e < LEN; e++) send_rnd();
    drain("t4");
    check("t4_result_count", pops_a - p0, 6);
    // LEN=1 instance: alternating single-element vectors
    b_m_ready = 1;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) send_b(2, AW'(-3), BW'(-1), 5);
      else send_b(10, 0, 10, 0);
    end
    b_s_valid = 0;
    for (int n = 0; n < 300 && (qbr.size() != 0 || b_m_valid); n++) tick();
    check("t5_result_count", pops_b, 12);
    check("t5_queue_empty", qbr.size(), 0);
    // reset with one result in flight and a partial vector
    for (int e = 0; e < LEN; e++) send(5, 0, 1, 0);
    send(1, 1, 1, 1);
    send(1, 1, 1, 1);
    @(negedge clk);
    check("t6_busy_before", busy, 1);
    tick();
    rst = 1;
    @(negedge clk);
    check("t6_rst_s_ready", s_ready, 0);
    tick();
    rst = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t6_no_valid", m_valid, 0);
      check("t6_busy", busy, 0);
      check("t6_m_pr", m_pr, 0);
      check("t6_mac_ar", mac_ar, 0);
      tick();
    end
    for (int i = 0; i < LEN; i++) begin
      send(1, 2, 3, 4);
      check("t6_sload", mac_sload, i == 0);
    end
    wait_result(-20, 40, "t6_after_rst");
    // random data, gaps and output backpressure
    rnd_mr = 1;
    for (int v = 0; v < 20; v++)
      for (int e = 0; e < LEN; e++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_rnd();
      end
    rnd_mr = 0;
    m_ready = 1;
    drain("rnd");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
